// File: rtl/sdram_arb_pkg.sv
// Shared FSM encoding and constants for the SDRAM Wishbone arbiter and its helpers.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

  function automatic int mask_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick; on a tie the requester that did not win last time is chosen.
module rr_arbiter2 (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last_grant,
  output logic o_grant_valid,
  output logic o_grant_id
);

  assign o_grant_valid = i_req0 | i_req1;
  assign o_grant_id    = (i_req0 & i_req1) ? ~i_last_grant : i_req1;

endmodule

// File: rtl/sdram_wb_arbiter.sv
// Shares one sdram_controller user port between two Wishbone-style requesters, one transaction at a time.
// Optional read-response watchdog is compiled in with `define SDRAM_ARB_TIMEOUT_EN.
module sdram_wb_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W         = 23,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              req0_valid,
  input  logic                              req0_we,
  input  logic [ADDR_W-1:0]                 req0_addr,
  input  logic [DATA_W-1:0]                 req0_wdata,
  input  logic [mask_width(DATA_W)-1:0]     req0_sel,
  output logic                              req0_ack,
  output logic [DATA_W-1:0]                 req0_rdata,
  input  logic                              req1_valid,
  input  logic                              req1_we,
  input  logic [ADDR_W-1:0]                 req1_addr,
  input  logic [DATA_W-1:0]                 req1_wdata,
  input  logic [mask_width(DATA_W)-1:0]     req1_sel,
  output logic                              req1_ack,
  output logic [DATA_W-1:0]                 req1_rdata,
  output logic [ADDR_W-1:0]                 ctrl_addr,
  output logic                              ctrl_rw,
  output logic [DATA_W-1:0]                 ctrl_wdata,
  output logic [mask_width(DATA_W)-1:0]     ctrl_mask,
  output logic                              ctrl_in_valid,
  input  logic                              ctrl_busy,
  input  logic [DATA_W-1:0]                 ctrl_rdata,
  input  logic                              ctrl_out_valid,
  output logic                              grant_id,
  output logic                              err
);

  localparam int MASK_W = mask_width(DATA_W);

  arb_state_t        r_state;
  logic              r_last_grant;
  logic              r_grant_id;
  logic [ADDR_W-1:0] r_addr;
  logic              r_rw;
  logic [DATA_W-1:0] r_wdata;
  logic [MASK_W-1:0] r_mask;
  logic              r_in_valid;
  logic [1:0]        r_ack;
  logic [DATA_W-1:0] r_rdata [2];

  logic              w_grant_valid;
  logic              w_grant_id;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [MASK_W-1:0] w_sel;

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] r_tmo;
  logic             r_err;
`endif

  rr_arbiter2 u_rr (
    .i_req0        (req0_valid),
    .i_req1        (req1_valid),
    .i_last_grant  (r_last_grant),
    .o_grant_valid (w_grant_valid),
    .o_grant_id    (w_grant_id)
  );

  // The request fields only feed the latch registers, never the ctrl_* ports directly.
  assign w_we    = w_grant_id ? req1_we    : req0_we;
  assign w_addr  = w_grant_id ? req1_addr  : req0_addr;
  assign w_wdata = w_grant_id ? req1_wdata : req0_wdata;
  assign w_sel   = w_grant_id ? req1_sel   : req0_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_grant_id   <= 1'b0;
      r_addr       <= '0;
      r_rw         <= 1'b0;
      r_wdata      <= '0;
      r_mask       <= '0;
      r_in_valid   <= 1'b0;
      r_ack        <= '0;
      r_rdata[0]   <= '0;
      r_rdata[1]   <= '0;
`ifdef SDRAM_ARB_TIMEOUT_EN
      r_tmo        <= '0;
      r_err        <= 1'b0;
`endif
    end else begin
      r_ack <= '0;
`ifdef SDRAM_ARB_TIMEOUT_EN
      r_err <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_grant_valid) begin
            r_grant_id   <= w_grant_id;
            r_last_grant <= w_grant_id;
            r_rw         <= w_we;
            r_addr       <= w_addr;
            r_wdata      <= w_wdata;
            r_mask       <= w_sel & {MASK_W{w_we}};
            r_in_valid   <= 1'b1;
            r_state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (!ctrl_busy) begin
            r_in_valid <= 1'b0;
            if (r_rw) begin
              r_ack[r_grant_id] <= 1'b1;
              r_state           <= DONE;
            end else begin
              r_state <= WAIT_RD;
            end
          end
        end
        WAIT_RD: begin
          if (ctrl_out_valid) begin
            r_rdata[r_grant_id] <= ctrl_rdata;
            r_ack[r_grant_id]   <= 1'b1;
            r_state             <= DONE;
`ifdef SDRAM_ARB_TIMEOUT_EN
            r_tmo               <= '0;
`endif
          end
`ifdef SDRAM_ARB_TIMEOUT_EN
          else if (r_tmo == TMO_LAST) begin
            r_rdata[r_grant_id] <= DATA_W'(TIMEOUT_RDATA);
            r_ack[r_grant_id]   <= 1'b1;
            r_err               <= 1'b1;
            r_tmo               <= '0;
            r_state             <= DONE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
`endif
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ctrl_addr     = r_addr;
  assign ctrl_rw       = r_rw;
  assign ctrl_wdata    = r_wdata;
  assign ctrl_mask     = r_mask;
  assign ctrl_in_valid = r_in_valid;
  assign req0_ack      = r_ack[0];
  assign req1_ack      = r_ack[1];
  assign req0_rdata    = r_rdata[0];
  assign req1_rdata    = r_rdata[1];
  assign grant_id      = r_grant_id;

`ifdef SDRAM_ARB_TIMEOUT_EN
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/sdram_wb_arbiter.md
Name: sdram_wb_arbiter

Overview:
- Shares the single `sdram_controller` user port between two Wishbone-style requesters.
  - Requester 0: the management-core Wishbone path.
  - Requester 1: a DMA/stream-refill engine feeding the FIR/matmul accelerators.
- Round-robin arbitration, one outstanding transaction at a time.
- Registers the winning request, drives the controller handshake (`in_valid`/`busy`/`out_valid`) and returns a one-cycle ack plus read data to the granted requester.
- Sits between the user-project address decode and `sdram_controller`.

Parameters:
- ADDR_W, 23, controller word-address width
- DATA_W, 32, data width (byte-mask width = DATA_W/8)
- TIMEOUT_CYCLES, 1024, read-response watchdog limit (used only with the optional feature)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- req0_valid  in  1  requester 0 cyc&stb; held until ack
- req0_we  in  1  1=write, 0=read
- req0_addr  in  ADDR_W  word address
- req0_wdata  in  DATA_W  write data
- req0_sel  in  DATA_W/8  byte select
- req0_ack  out  1  one-cycle completion pulse
- req0_rdata  out  DATA_W  read data, valid with req0_ack
- req1_valid, req1_we, req1_addr, req1_wdata, req1_sel, req1_ack, req1_rdata: identical to requester 0
- ctrl_addr  out  ADDR_W  to controller user_addr
- ctrl_rw  out  1  to controller rw
- ctrl_wdata  out  DATA_W  to controller data_in
- ctrl_mask  out  DATA_W/8  byte mask = latched sel & {we}
- ctrl_in_valid  out  1  request strobe
- ctrl_busy  in  1  controller busy
- ctrl_rdata  in  DATA_W  controller data_out
- ctrl_out_valid  in  1  read data valid
- grant_id  out  1  current/last granted requester (debug)
- err  out  1  timeout flag pulse (0 when feature compiled out)

Behaviour:
- Clock and reset: one clock, `clk`. `rst` is asynchronous, active-high.
- Reset values: all outputs 0; FSM=IDLE; last_grant=1, so requester 0 wins the first tie.
- Registered outputs: all `ctrl_*` outputs and acks are registered. No combinational path from `req*` to `ctrl_*`.
- FSM states: IDLE, ISSUE, WAIT_RD, DONE.
- IDLE:
  - Only req0 valid -> grant 0. Only req1 valid -> grant 1.
  - Both valid -> grant the requester that is not last_grant.
  - On grant: latch we/addr/wdata/sel into the `ctrl_*` regs, set grant_id and last_grant, go to ISSUE.
  - No requests -> stay in IDLE.
- ISSUE:
  - ctrl_in_valid=1.
  - Held while ctrl_busy=1.
  - At the first edge with ctrl_busy=0: drop ctrl_in_valid.
    - Write: assert ack of the granted requester, go to DONE.
    - Read: go to WAIT_RD.
- WAIT_RD:
  - ctrl_in_valid=0.
  - On ctrl_out_valid: capture ctrl_rdata into the granted reqN_rdata, assert reqN_ack, go to DONE.
- DONE:
  - The ack pulse is high for exactly this one cycle; then go to IDLE.
  - The requester is sampled again no earlier than the next IDLE cycle, so a master that drops stb on ack is never double-served.
- Latency, write: request to ack is 3 cycles when the controller is idle.
- Latency, read: 3 cycles plus controller read latency.
- Mid-transaction request changes: changes on any reqN_* inputs after grant are ignored (latched copy is used). A requester dropping valid mid-transaction still gets its ack; the ack is harmless.
- Read data hold: reqN_rdata holds its last captured value between reads.
- Non-granted acks: the ack of the non-granted requester is always 0.
- Unexpected response: ctrl_out_valid in IDLE/ISSUE/DONE is ignored.
- Reset mid-operation: immediate return to IDLE. The in-flight transaction is dropped without ack and ctrl_in_valid is forced to 0.

Optional Feature:
- Macro: SDRAM_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_RD.
  - When it reaches TIMEOUT_CYCLES without ctrl_out_valid: ack the granted requester with rdata=32'hDEAD_BEEF, pulse err for 1 cycle, go to DONE.
  - The counter clears on leaving WAIT_RD.
- Not defined:
  - No counter; WAIT_RD waits indefinitely.
  - err is tied to 0.

Decomposition:
- Shared package `sdram_arb_pkg`:
  - FSM state enum (IDLE, ISSUE, WAIT_RD, DONE).
  - Localparam TIMEOUT_RDATA=32'hDEAD_BEEF.
  - Mask width derivation.
- Sub-module `rr_arbiter2`: combinational 2-way round-robin pick from (req0, req1, last_grant), outputting grant_valid and grant_id. Reusable for a later FIR/matmul stream arbiter.

Test Plan:
- Single write: req0 write addr 0x000010, data 0x12345678, sel 4'hF, controller idle -> ctrl_in_valid 1 cycle, ctrl_mask=4'hF, ctrl_rw=1; req0_ack exactly one pulse 3 cycles after request; req1_ack stays 0.
- Single read: req1 read addr 0x000010; controller returns 0x12345678 5 cycles after accept -> req1_rdata=0x12345678 with req1_ack; grant_id=1.
- Simultaneous requests: both valid from reset -> req0 served first, then req1. Both held for 4 back-to-back transactions -> grants alternate 0,1,0,1.
- Busy backpressure: ctrl_busy=1 for 7 cycles during ISSUE -> ctrl_in_valid held 7+1 cycles with stable addr/data; a single ack follows.
- Reset mid-read: assert rst in WAIT_RD -> all outputs 0 asynchronously, no ack. A later ctrl_out_valid in IDLE is ignored; the next req0 is served normally.
- Timeout (SDRAM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16): read with no ctrl_out_valid -> ack after 16 WAIT_RD cycles with rdata=0xDEADBEEF and err pulse.
